// File: rtl/nibble_uart_pkg.sv
// nibble_uart_pkg: shared types and constants for the nibble UART transmitter.
// NIBBLE_TX_PARITY_EN adds the PARITY state to the frame.
package nibble_uart_pkg;
    localparam int DATA_BITS = 4;
    localparam int IDX_W = 2;
    localparam logic IDLE_LEVEL = 1'b1;
`ifdef NIBBLE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif
endpackage

// File: rtl/nibble_baud_gen.sv
// nibble_baud_gen: bit-time counter; bit_end marks the last clk of each serial bit.
module nibble_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign cnt_d = (clear || bit_end) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: pops nibbles from a FIFO and sends each as start, 4 data LSB-first, stop.
// NIBBLE_TX_PARITY_EN inserts an even parity bit before the stop bit.
module nibble_uart_tx
    import nibble_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 rd_en,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);
`ifdef NIBBLE_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
    logic par_q, par_d;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif
    tx_state_t state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic bit_end, tx_d;

    // Gated by reset so no pop can escape while the block is held in reset
    assign rd_en = reset & (state_q == IDLE) & tx_en & ~fifo_empty;

    nibble_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (rd_en | ((state_q != IDLE) & bit_end)),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
`ifdef NIBBLE_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (rd_en) begin
                state_d = START;
                shreg_d = fifo_data;
`ifdef NIBBLE_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
            end
            START: if (bit_end) state_d = DATA;
            DATA: if (bit_end) begin
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = AFTER_DATA;
            end
`ifdef NIBBLE_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Line level is a function of the state being entered so tx_out can be registered
        tx_d = IDLE_LEVEL;
        if (state_d == START) tx_d = 1'b0;
        if (state_d == DATA)  tx_d = shreg_d[0];
`ifdef NIBBLE_TX_PARITY_EN
        if (state_d == PARITY) tx_d = par_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
`ifdef NIBBLE_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
            tx_out     <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
`ifdef NIBBLE_TX_PARITY_EN
            par_q      <= par_d;
`endif
            tx_out     <= tx_d;
            busy       <= (state_d != IDLE);
            frame_done <= (state_q == STOP) & bit_end;
        end
    end
endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb_nibble_uart_tx: FIFO model + line-decoding monitor with a scoreboard of popped nibbles.
module tb_nibble_uart_tx;
    localparam int N = 4;
`ifdef NIBBLE_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int FL = NB * N;

    logic clk = 0, reset = 0, tx_en = 0, fifo_empty = 1;
    logic [3:0] fifo_data = 4'h0;
    logic rd_en, tx_out, busy, frame_done;

    int total = 0, bad = 0;
    int cyc = 0, rem = 0, pops = 0, frames = 0, dones = 0, underflow = 0;
    int last_pop = -100, done_cyc = 0, k = 0;
    logic fd_exp = 0, infr = 0;
    logic [7:0] bitv = 8'h0;
    logic [3:0] fifo_q[$];
    logic [3:0] exp_q[$];
    int pop_cycs[$];

    always #5 clk = ~clk;

    nibble_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .rd_en(rd_en), .tx_out(tx_out), .busy(busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model and frame-length timer: a pop makes the line busy for exactly FL cycles
    always @(posedge clk) begin
        cyc++;
        fd_exp = 0;
        if (!reset) rem = 0;
        else if (rd_en) begin
            if (fifo_q.size() == 0) underflow++;
            else exp_q.push_back(fifo_q.pop_front());
            pops++;
            last_pop = cyc;
            pop_cycs.push_back(cyc);
            rem = FL;
        end else if (rem > 0) begin
            rem--;
            fd_exp = (rem == 0);
        end
        #1;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data = fifo_empty ? 4'h0 : fifo_q[0];
    end

    // Monitor: checks control outputs every cycle and decodes frames off the serial line
    always @(negedge clk) begin
        chk("rd_en", rd_en, reset & tx_en & ~fifo_empty & (rem == 0));
        chk("busy", busy, reset && rem != 0);
        chk("frame_done", frame_done, reset && fd_exp);
        if (frame_done) begin
            dones++;
            done_cyc = cyc;
        end
        if (!reset) begin
            infr = 0;
            exp_q.delete();
        end else begin
            if (!infr && tx_out === 1'b0) begin
                infr = 1;
                k = 0;
                chk("start_after_pop", cyc, last_pop);
            end
            if (infr) begin
                if (k % N == 0) bitv[k/N] = tx_out;
                else chk("bit_hold", tx_out, bitv[k/N]);
                k++;
                if (k == FL) begin
                    infr = 0;
                    frames++;
                    chk("start_bit", bitv[0], 1'b0);
                    chk("stop_bit", bitv[NB-1], 1'b1);
                    if (exp_q.size() == 0) chk("frame_expected", 0, 1);
                    else begin
                        logic [3:0] e;
                        e = exp_q.pop_front();
                        chk("data", bitv[4:1], e);
                        if (NB == 7) chk("parity", bitv[5], ^e);
                    end
                end
            end
        end
    end

    task automatic wait_dones(input int target, input int budget);
        int t = 0;
        while (dones < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_frame_done", dones >= target, 1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int t = 0;
        while (pops < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_pop", pops >= target, 1);
    endtask

    initial begin
        int t;
        fifo_q.push_back(4'b1011);
        tx_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_en", rd_en, 0);
        #2 reset = 1;
        // single frame
        wait_dones(1, 200);
        chk("pop_to_done", done_cyc - last_pop, FL);
        chk("single_pops", pops, 1);
        // back-to-back
        fifo_q.push_back(4'h3);
        fifo_q.push_back(4'hA);
        fifo_q.push_back(4'hF);
        wait_dones(4, 400);
        chk("b2b_pops", pops, 4);
        chk("b2b_gap1", pop_cycs[2] - pop_cycs[1], FL + 1);
        chk("b2b_gap2", pop_cycs[3] - pop_cycs[2], FL + 1);
        // empty FIFO
        repeat (100) @(negedge clk);
        chk("empty_pops", pops, 4);
        // reset during data bit 2
        fifo_q.push_back(4'h5);
        wait_pops(5, 100);
        repeat (3 * N + 1) @(negedge clk);
        #2 reset = 0;
        #1;
        chk("midrst_tx_out", tx_out, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        fifo_q.push_back(4'h6);
        #2 reset = 1;
        wait_dones(dones + 1, 200);
        chk("post_rst_frames", frames, 5);
        // tx_en dropped during the start bit
        fifo_q.push_back(4'h7);
        fifo_q.push_back(4'h9);
        wait_pops(7, 100);
        tx_en = 0;
        wait_dones(dones + 1, 200);
        repeat (20) @(negedge clk);
        chk("txen_hold_pops", pops, 7);
        tx_en = 1;
        wait_dones(dones + 1, 200);
        chk("txen_resume_pops", pops, 8);
        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back(4'($urandom));
            tx_en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        tx_en = 1;
        t = 0;
        while ((fifo_q.size() != 0 || rem != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain_done", fifo_q.size() == 0 && rem == 0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frames_vs_pops", frames, pops - 1);
        chk("dones_vs_frames", dones, frames);
        chk("underflow", underflow, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
